// File: rtl/max5216_writer.sv
// max5216_writer: SPI write engine for the MAX5216 16-bit DAC.
// One-word holding buffer feeding 24-bit write-through frames.
module max5216_writer #(
  parameter int SCLK_DIV   = 4,
  parameter int CSS_CYCLES = 2,
  parameter int CSH_CYCLES = 1,
  parameter int CSW_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        busy,
  output logic        done,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n
);

  if (SCLK_DIV < 2 || (SCLK_DIV % 2) != 0) begin : g_bad_div
    $error("SCLK_DIV must be even and >= 2");
  end
  if (CSS_CYCLES < 1 || CSH_CYCLES < 1 || CSW_CYCLES < 1) begin : g_bad_cs
    $error("CS timing parameters must be >= 1");
  end

  localparam int CW = 16;
  localparam logic [CW-1:0] DIV_LAST = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] HALF     = CW'(SCLK_DIV / 2);
  localparam logic [CW-1:0] CSS_LAST = CW'(CSS_CYCLES - 1);
  localparam logic [CW-1:0] CSH_LAST = CW'(CSH_CYCLES - 1);
  localparam logic [CW-1:0] CSW_LAST = CW'(CSW_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, GAP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0]    bitn, bitn_n;
  logic [23:0]   sr, sr_n;
  logic [15:0]   pend_data;
  logic          pend_valid;
  logic          load, drain;
  logic          sclk_n, cs_n_n, busy_n, done_n;

  assign s_ready  = !pend_valid;
  assign load     = s_valid && !pend_valid;
  assign spi_mosi = sr[23];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
    end else if (load) begin
      pend_valid <= 1'b1;
      pend_data  <= s_data;
    end else if (drain) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= '0;
      bitn     <= '0;
      sr       <= '0;
      spi_sclk <= 1'b0;
      spi_cs_n <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bitn     <= bitn_n;
      sr       <= sr_n;
      spi_sclk <= sclk_n;
      spi_cs_n <= cs_n_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    bitn_n  = bitn;
    sr_n    = sr;
    drain   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (pend_valid) state_n = SETUP;
      end
      SETUP: begin
        if (cnt == CSS_LAST) begin
          state_n = SHIFT;
          cnt_n   = '0;
          bitn_n  = '0;
        end
      end
      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_n  = '0;
          sr_n   = {sr[22:0], 1'b0};
          bitn_n = bitn + 5'd1;
          if (bitn == 5'd23) begin
            state_n = HOLD;
            bitn_n  = '0;
          end
        end
      end
      HOLD: begin
        if (cnt == CSH_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end
      end
      GAP: begin
        if (cnt == CSW_LAST) begin
          cnt_n   = '0;
          state_n = pend_valid ? SETUP : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Frame load happens on the edge that enters SETUP.
    if (state_n == SETUP && state != SETUP) begin
      drain = 1'b1;
      sr_n  = {2'b01, pend_data, 6'b000000};
      cnt_n = '0;
    end
  end

  always_comb begin
    cs_n_n = !(state_n inside {SETUP, SHIFT, HOLD});
    sclk_n = (state_n == SHIFT) && (cnt_n >= HALF);
    busy_n = (state_n != IDLE);
    done_n = (state == HOLD) && (state_n == GAP);
  end

endmodule

// File: tb/tb_max5216_writer.sv
// tb_max5216_writer: three parameter sets driven against a
// timeline model of the MAX5216 frame, plus literal pins.
module tb_max5216_writer;

  function automatic int p_div(int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : 8;
  endfunction
  function automatic int p_css(int k);
    return (k == 0) ? 2 : 1;
  endfunction
  function automatic int p_csh(int k);
    return (k == 0) ? 1 : 3;
  endfunction
  function automatic int p_csw(int k);
    return (k == 0) ? 2 : 4;
  endfunction
  function automatic int p_len(int k);
    return p_css(k) + 24 * p_div(k) + p_csh(k);
  endfunction

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic sv[3], sclk[3], mosi[3], csn[3];
  logic busy[3], done[3], rdy[3];
  logic [15:0] sd[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    max5216_writer #(
      .SCLK_DIV  (p_div(g)),
      .CSS_CYCLES(p_css(g)),
      .CSH_CYCLES(p_csh(g)),
      .CSW_CYCLES(p_csw(g))
    ) u_dut (
      .clk     (clk),
      .resetn  (resetn),
      .s_data  (sd[g]),
      .s_valid (sv[g]),
      .s_ready (rdy[g]),
      .busy    (busy[g]),
      .done    (done[g]),
      .spi_sclk(sclk[g]),
      .spi_mosi(mosi[g]),
      .spi_cs_n(csn[g])
    );
  end

  // Model state: pending word and position within the current frame.
  logic        m_pv[3];
  logic        m_act[3];
  int          m_t[3];
  logic [15:0] m_pd[3];
  logic [23:0] m_fr[3];

  // Source queues (main pushes, model pops) and drained-word log.
  logic [15:0] qw[3][256];
  int          qt[3] = '{0, 0, 0};
  int          qh[3] = '{0, 0, 0};
  logic [15:0] sw[3][256];
  int          st[3] = '{0, 0, 0};
  int          sh[3] = '{0, 0, 0};

  int   err = 0;
  int   chk = 0;
  int   cyc = 0;
  int   nprint = 0;
  logic junk_en = 1'b0;

  logic        psclk[3] = '{0, 0, 0};
  logic        pcsn[3]  = '{1, 1, 1};
  logic [23:0] cap[3];
  int          nr[3]       = '{0, 0, 0};
  int          low[3]      = '{0, 0, 0};
  logic [23:0] lastcap[3];
  int          lastlow[3]  = '{0, 0, 0};
  int          nframes[3]  = '{0, 0, 0};
  int          ndone[3]    = '{0, 0, 0};
  int          nfall[3]    = '{0, 0, 0};
  int          lastrise[3] = '{0, 0, 0};
  int          fallc[3][256];
  int          gapl[3][256];

  always @(posedge clk) begin : model
    logic        act, pv, hs;
    int          t;
    logic [15:0] pd;
    logic [23:0] fr;
    for (int k = 0; k < 3; k++) begin
      act = m_act[k];
      pv  = m_pv[k];
      t   = m_t[k];
      pd  = m_pd[k];
      fr  = m_fr[k];
      hs  = resetn && sv[k] && !pv;
      if (!resetn) begin
        act = 1'b0;
        pv  = 1'b0;
        t   = 0;
      end else begin
        if (act) begin
          t = t + 1;
          if (t == p_len(k) + p_csw(k)) act = 1'b0;
        end
        if (!act && pv) begin
          act = 1'b1;
          t   = 0;
          fr  = {2'b01, pd, 6'b000000};
          pv  = 1'b0;
          sw[k][st[k]] <= pd;
          st[k] <= st[k] + 1;
        end
        if (hs) begin
          pv = 1'b1;
          pd = sd[k];
          qh[k] <= qh[k] + 1;
        end
      end
      m_act[k] <= act;
      m_pv[k]  <= pv;
      m_t[k]   <= t;
      m_pd[k]  <= pd;
      m_fr[k]  <= fr;
    end
  end

  // {cs_n, sclk, mosi, busy, done, s_ready} from the frame timeline.
  function automatic logic [5:0] expv(int k);
    logic c, s, m, b, d;
    int   t, j;
    c = 1'b1; s = 1'b0; m = 1'b0; b = 1'b0; d = 1'b0;
    if (m_act[k]) begin
      t = m_t[k];
      b = 1'b1;
      d = (t == p_len(k));
      if (t < p_len(k)) c = 1'b0;
      if (t < p_css(k)) begin
        m = m_fr[k][23];
      end else if (t < p_css(k) + 24 * p_div(k)) begin
        j = t - p_css(k);
        s = (j % p_div(k)) >= (p_div(k) / 2);
        m = m_fr[k][23 - j / p_div(k)];
      end
    end
    return {c, s, m, b, d, !m_pv[k]};
  endfunction

  function automatic logic all_idle();
    logic r;
    r = 1'b1;
    for (int k = 0; k < 3; k++)
      if (m_act[k] || m_pv[k] || qh[k] != qt[k]) r = 1'b0;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
    chk++;
    if (act !== want) begin
      err++;
      $display("FAIL %s got=%0h want=%0h", nm, act, want);
    end
  endtask

  task automatic push(input int k, input logic [15:0] w);
    qw[k][qt[k]] = w;
    qt[k]++;
  endtask

  task automatic tick();
    logic [5:0]  a, e;
    logic [23:0] ef;
    logic        rst_seen;
    rst_seen = !resetn;
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) begin
      e = expv(k);
      a = {csn[k], sclk[k], mosi[k], busy[k], done[k], rdy[k]};
      chk++;
      if (a !== e) begin
        err++;
        if (nprint < 30) begin
          nprint++;
          $display("FAIL pins dut%0d cyc=%0d got=%b want=%b", k, cyc, a, e);
        end
      end
      if (done[k]) ndone[k]++;
      if (rst_seen) begin
        nr[k] = 0; cap[k] = '0; low[k] = 0; sh[k] = st[k];
      end else begin
        if (!csn[k]) low[k]++;
        if (sclk[k] && !psclk[k] && !csn[k]) begin
          cap[k] = {cap[k][22:0], mosi[k]};
          nr[k]++;
        end
        if (!csn[k] && pcsn[k]) begin
          if (nfall[k] < 256) begin
            fallc[k][nfall[k]] = cyc;
            gapl[k][nfall[k]]  = cyc - lastrise[k];
          end
          nfall[k]++;
        end
        if (csn[k] && !pcsn[k]) begin
          lastrise[k] = cyc;
          ef = (sh[k] != st[k]) ? {2'b01, sw[k][sh[k]], 6'b0} : 24'hFFFFFF;
          if (sh[k] != st[k]) sh[k]++;
          chk++;
          if (nr[k] != 24 || cap[k] !== ef || low[k] != p_len(k)) begin
            err++;
            $display("FAIL frame dut%0d rises=%0d bits=%h low=%0d want 24/%h/%0d",
                     k, nr[k], cap[k], low[k], ef, p_len(k));
          end
          lastcap[k] = cap[k];
          lastlow[k] = low[k];
          nframes[k]++;
          nr[k] = 0; cap[k] = '0; low[k] = 0;
        end
      end
      psclk[k] = sclk[k];
      pcsn[k]  = csn[k];
      if (qh[k] != qt[k]) begin
        sv[k] = 1'b1;
        sd[k] = qw[k][qh[k]];
      end else if (junk_en && m_pv[k] && $urandom_range(0, 3) == 0) begin
        sv[k] = 1'b1;
        sd[k] = 16'($urandom);
      end else begin
        sv[k] = 1'b0;
        sd[k] = 16'($urandom);
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!all_idle() && n < 3000) begin
      tick();
      n++;
    end
    chk++;
    if (!all_idle()) begin
      err++;
      $display("FAIL idle_timeout got=busy want=idle");
    end
  endtask

  initial begin : main
    int c, nf0, nfr;
    for (int k = 0; k < 3; k++) begin
      sv[k] = 1'b0;
      sd[k] = '0;
    end
    resetn = 1'b0;
    repeat (3) tick();
    check("reset_state",
          32'({csn[0], sclk[0], mosi[0], busy[0], done[0], rdy[0]}),
          32'b100001);
    resetn = 1'b1;
    tick();

    // Single word.
    nf0 = nfall[0];
    ndone[0] = 0;
    for (int k = 0; k < 3; k++) push(k, 16'hA5C3);
    tick();
    c = cyc;
    wait_idle();
    check("cs_fall_delay", 32'(fallc[0][nf0] - c), 32'd2);
    check("frame_a5c3", 32'(lastcap[0]), 32'h006970C0);
    check("cs_low_len", 32'(lastlow[0]), 32'd99);
    check("done_once", 32'(ndone[0]), 32'd1);
    check("busy_after_gap", 32'(busy[0]), 32'd0);
    check("cs_low_div2", 32'(lastlow[1]), 32'd52);
    check("cs_low_div8", 32'(lastlow[2]), 32'd196);

    // Back-to-back stream with s_valid held high.
    nf0 = nfall[0];
    nfr = nframes[0];
    for (int k = 0; k < 3; k++) begin
      push(k, 16'h0001);
      push(k, 16'hFFFF);
      push(k, 16'h8000);
    end
    wait_idle();
    check("spacing_1", 32'(fallc[0][nf0+1] - fallc[0][nf0]), 32'd101);
    check("spacing_2", 32'(fallc[0][nf0+2] - fallc[0][nf0+1]), 32'd101);
    check("gap_1", 32'(gapl[0][nf0+1]), 32'd2);
    check("gap_2", 32'(gapl[0][nf0+2]), 32'd2);
    check("frame_8000", 32'(lastcap[0]), 32'h00600000);
    check("stream_frames", 32'(nframes[0] - nfr), 32'd3);

    // Random traffic with junk pulses while the buffer is full.
    junk_en = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, 59) == 0 && qt[k] - qh[k] < 2)
          push(k, 16'($urandom));
      tick();
    end
    junk_en = 1'b0;
    wait_idle();

    // Reset at the 10th rising edge with a second word pending.
    nfr = nframes[0];
    for (int k = 0; k < 3; k++) begin
      push(k, 16'h1234);
      push(k, 16'h4321);
    end
    for (int n = 0; n < 500 && nr[0] != 10; n++) tick();
    check("tenth_rise", 32'(nr[0]), 32'd10);
    check("word_pending", 32'(rdy[0]), 32'd0);
    resetn = 1'b0;
    tick();
    check("reset_abort",
          32'({csn[0], sclk[0], mosi[0], busy[0], done[0], rdy[0]}),
          32'b100001);
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) qt[k] = qh[k];
    nf0 = nfall[0];
    ndone[0] = 0;
    repeat (300) tick();
    check("no_cs_after_reset", 32'(nfall[0] - nf0), 32'd0);
    check("no_done_after_reset", 32'(ndone[0]), 32'd0);
    check("aborted_not_counted", 32'(nframes[0] - nfr), 32'd0);

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule

// File: doc/max5216_writer.md
# max5216_writer

SPI transmit engine driving a MAX5216 16-bit DAC over a PMOD port. It is the output-side counterpart of the MAX11100 ADC reader. It accepts 16-bit codes through a valid/ready handshake and buffers one word. For each word it emits a 24-bit write-through frame with programmable SCLK divide and CS timing, and it supports back-to-back frames.

## Interface
Parameters:
- SCLK_DIV, 4: clk cycles per SCLK period; even, ≥2. Elaboration error otherwise.
- CSS_CYCLES, 2: cycles from CS falling to the first SCLK period; ≥1.
- CSH_CYCLES, 1: cycles from the last SCLK falling edge to CS rising; ≥1.
- CSW_CYCLES, 2: minimum CS-high cycles between frames; ≥1.

Ports:
- clk  in  1  system clock (100 MHz nominal).
- resetn  in  1  synchronous, active-low reset.
- s_data  in  16  DAC code, captured on handshake.
- s_valid  in  1  s_data valid; the source holds s_data until accepted.
- s_ready  out  1  holding register empty (= !pend_valid).
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- spi_sclk  out  1  SPI clock, CPOL=0. The DAC samples on the rising edge.
- spi_mosi  out  1  serial data, MSB first.
- spi_cs_n  out  1  DAC chip select, active low.

## Operation
- Reset values: spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, pend_valid=0 (so s_ready=1). FSM goes to IDLE.
- Holding register:
  - A handshake (s_valid && s_ready at a clk edge) loads pend_data and sets pend_valid.
  - A load and a drain can never occur in the same cycle.
- Frame format: {2'b01, pend_data[15:0], 6'b000000}, 24 bits, bit 23 first. Control 01 = write-through.
- FSM states:
  - IDLE: cs_n=1, sclk=0, mosi=0.
    - If pend_valid, go to SETUP.
  - SETUP: entered from IDLE or GAP when pend_valid.
    - On entry: shift register ← frame, pend_valid ← 0, cs_n=0, mosi=frame[23].
    - Lasts CSS_CYCLES cycles with sclk=0, then go to SHIFT.
  - SHIFT: 24 bit periods of SCLK_DIV cycles each.
    - In each period, sclk=0 for the first SCLK_DIV/2 cycles and 1 for the last SCLK_DIV/2 cycles.
    - mosi changes only at period start, i.e. coincident with the sclk falling edge, or with SETUP exit for bit 23.
    - A bit counter of 0..23 and a divider counter of 0..SCLK_DIV-1 both wrap to 0.
    - After the 24th period, go to HOLD.
  - HOLD: sclk=0, cs_n=0 for CSH_CYCLES cycles, then go to GAP.
  - GAP: cs_n=1, mosi=0, for CSW_CYCLES cycles.
    - done=1 in the first GAP cycle only.
    - On exit, go to SETUP if pend_valid, else IDLE.
- s_ready stays live during a frame, so the next word can be queued for gapless streaming.
- busy = (state != IDLE).
- Reset mid-frame: the next edge forces the reset values, drops the pending word and aborts the frame with cs_n high. The DAC discards partial frames.

## Timing
- Handshake at edge E0 → pend_valid=1 after E0 → SETUP entered at E1, with spi_cs_n=0 from E1.
- First sclk rise: E1 + CSS_CYCLES + SCLK_DIV/2.
- Frame length, CS low: CSS_CYCLES + 24·SCLK_DIV + CSH_CYCLES. Defaults: 2+96+1 = 99 cycles.
- Back-to-back period: frame length + CSW_CYCLES. Defaults: 101 cycles (≈990 ksps ceiling).
- done asserts in the cycle cs_n first reads 1.
- MOSI setup to sclk rise and hold after it: SCLK_DIV/2 cycles each. Defaults: 20 ns each.
- Defaults give SCLK = 25 MHz. The MAX5216 limit is 50 MHz, so SCLK_DIV=2 is legal.
- All outputs are registered; no combinational path from s_valid to SPI pins.

## Test plan
- Reset, then a single word 0xA5C3: spi_cs_n falls 2 cycles after the handshake cycle. A model sampling mosi on sclk rise captures 24'h6970C0 ({01, A5C3, 000000}). done pulses once. busy deasserts after GAP. Total CS-low time = 99 cycles.
- s_valid held high with words 0x0001, 0xFFFF, 0x8000:
  - s_ready drops after each accept and reasserts in the SETUP cycle of the frame draining it.
  - Frames are spaced exactly 101 cycles cs-fall to cs-fall, with exactly CSW_CYCLES=2 high cycles between.
  - Captured codes match in order.
- Parameter sweep SCLK_DIV=2 and 8, CSS_CYCLES=1/CSH_CYCLES=3/CSW_CYCLES=4:
  - Exactly 24 sclk rising edges per frame.
  - sclk high time = SCLK_DIV/2.
  - mosi is stable for SCLK_DIV/2 cycles on either side of each rise.
  - CS-low time = CSS+24·DIV+CSH.
- resetn low for 1 cycle at the 10th sclk rise, with a word pending: the next cycle shows cs_n=1, sclk=0, mosi=0, busy=0, s_ready=1. The pending word is never sent and no done pulse occurs.
- s_valid pulsed while s_ready=0: no capture. pend_data is unchanged and the next frame carries the earlier accepted word.
